// File: rtl/rotating_square_ctrl_pkg.sv
// Shared constants and helpers for the rotating-square display controller:
// segment patterns, digit/position counts and the position-to-digit mapping.
package rotating_square_ctrl_pkg;

  localparam int DIGITS    = 4;
  localparam int POSITIONS = 8;
  localparam int POS_W     = 3;

  typedef logic [7:0] seg_t;

  localparam seg_t SSEG_TOP   = 8'h9C;
  localparam seg_t SSEG_BOT   = 8'hA3;
  localparam seg_t SSEG_BLANK = 8'hFF;

  // Upper half runs left-to-right on digits 0..3, lower half returns on 3..0.
  function automatic logic [1:0] pos_digit(input logic [POS_W-1:0] p);
    return p[2] ? ~p[1:0] : p[1:0];
  endfunction

  function automatic seg_t pos_pattern(input logic [POS_W-1:0] p);
    return p[2] ? SSEG_BOT : SSEG_TOP;
  endfunction

endpackage

// File: rtl/rotating_square_ctrl_led_mux4.sv
// Four-digit time multiplexer: free-running refresh counter whose top two
// bits pick the digit, with registered active-low anode and segment outputs.
module led_mux4
  import rotating_square_ctrl_pkg::*;
#(
  parameter int REFRESH_N = 18
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [DIGITS-1:0][7:0]  digits,
  output logic [3:0]              an,
  output logic [7:0]              sseg
);

  logic [REFRESH_N-1:0] cnt;
  logic [1:0]           sel;

  assign sel = cnt[REFRESH_N-1:REFRESH_N-2];

  // Refresh counter and output register; outputs lag sel by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt  <= {REFRESH_N{1'b0}};
      an   <= 4'b1111;
      sseg <= SSEG_BLANK;
    end else begin
      cnt  <= cnt + {{(REFRESH_N-1){1'b0}}, 1'b1};
      an   <= ~(4'b0001 << sel);
      sseg <= digits[sel];
    end
  end

endmodule

// File: rtl/rotating_square_ctrl.sv
// Rotating-square controller: tick-driven position register plus per-digit
// pattern builder feeding the four-digit display multiplexer.
module rotating_square_ctrl
  import rotating_square_ctrl_pkg::*;
#(
  parameter int REFRESH_N = 18
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             en,
  input  logic             cw,
  output logic [POS_W-1:0] pos,
  output logic [3:0]       an,
  output logic [7:0]       sseg
);

  logic [DIGITS-1:0][7:0] digits;

  // Position register: one step per accepted tick, 3-bit wrap both ways.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos <= 3'd0;
    end else if (tick && en) begin
      pos <= cw ? pos + 3'd1 : pos - 3'd1;
    end else begin
      pos <= pos;
    end
  end

  // Only the digit under the square gets a pattern; the rest stay blank.
  always_comb begin
    digits = {DIGITS{SSEG_BLANK}};
    for (int i = 0; i < DIGITS; i++) begin
      if (pos_digit(pos) == 2'(i)) begin
        digits[i] = pos_pattern(pos);
      end else begin
        digits[i] = SSEG_BLANK;
      end
    end
  end

  led_mux4 #(
    .REFRESH_N (REFRESH_N)
  ) u_mux (
    .clk    (clk),
    .reset  (reset),
    .digits (digits),
    .an     (an),
    .sseg   (sseg)
  );

endmodule

// File: tb/tb_rotating_square_ctrl.sv
// Scoreboard bench for rotating_square_ctrl (REFRESH_N=4): directed and random
// tick/en/cw stimulus against an arithmetic reference model.
module tb_rotating_square_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick, en, cw;
  logic [2:0] pos;
  logic [3:0] an;
  logic [7:0] sseg;

  typedef struct {
    logic [2:0] pos;
    logic [3:0] an;
    logic [7:0] sseg;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_fail = 0;
  int   m_pos  = 0;
  int   m_cnt  = 0;

  rotating_square_ctrl #(.REFRESH_N(4)) dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .en    (en),
    .cw    (cw),
    .pos   (pos),
    .an    (an),
    .sseg  (sseg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference: digit i is selected during cycles [4i, 4i+3] of each 16-cycle period.
  task automatic step(input logic t, input logic e, input logic c);
    exp_t x;
    int   dig, tgt;
    logic [7:0] pat;
    tick = t; en = e; cw = c;
    @(posedge clk);
    dig    = (m_cnt % 16) / 4;
    x.an   = 4'hF ^ 4'(1 << dig);
    tgt    = (m_pos < 4) ? m_pos : 7 - m_pos;
    pat    = (m_pos < 4) ? 8'h9C : 8'hA3;
    x.sseg = (tgt == dig) ? pat : 8'hFF;
    if (t && e) m_pos = c ? (m_pos + 1) % 8 : (m_pos + 7) % 8;
    m_cnt  = m_cnt + 1;
    x.pos  = 3'(m_pos);
    exp_q.push_back(x);
    #1;
  endtask

  // Monitor: every clock presents a new output word.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pos",  {5'd0, pos}, {5'd0, e.pos});
      chk("an",   {4'd0, an},  {4'd0, e.an});
      chk("sseg", sseg,        e.sseg);
      chk("an_onehot_low", 8'($countones(an)), 8'd3);
    end
  end

  task automatic drain();
    repeat (2) @(negedge clk);
    #1;
    chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pos"},  {5'd0, pos}, 8'd0);
    chk({tag, "_an"},   {4'd0, an},  8'h0F);
    chk({tag, "_sseg"}, sseg,        8'hFF);
  endtask

  initial begin
    reset = 1'b0; tick = 1'b0; en = 1'b0; cw = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    @(posedge clk); #1;
    reset = 1'b1;
    m_pos = 0; m_cnt = 0;

    // CW walk: 9 single-cycle ticks with idle gaps
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
    end
    // Sit at pos 4 for a full refresh period
    while (m_pos != 4) step(1'b1, 1'b1, 1'b1);
    repeat (16) step(1'b0, 1'b1, 1'b1);

    // CCW wrap from 0 to 7, then watch digit 0
    while (m_pos != 0) step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    repeat (16) step(1'b0, 1'b0, 1'b0);

    // Pause: ticks with en=0
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
    end

    // Held tick from pos 2, then cw toggles between separate ticks
    while (m_pos != 2) step(1'b1, 1'b1, 1'b1);
    repeat (3) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1);

    // Mux sweep: every position over a full refresh period
    for (int p = 0; p < 8; p++) begin
      repeat (16) step(1'b0, 1'b1, 1'b1);
      step(1'b1, 1'b1, 1'b1);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    end

    // Mid-run asynchronous reset from pos 5
    while (m_pos != 5) step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    drain();
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    tick = 1'b1; en = 1'b1; cw = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    @(posedge clk); #1;
    reset = 1'b1;
    m_pos = 0; m_cnt = 0;
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)));
    end

    drain();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
